// File: rtl/maze_pkg.sv
// ============================================================================
// Package     : maze_pkg
// Description : Shared button indices, channel state encoding and defaults.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package maze_pkg;

    localparam int BTN_C = 0;
    localparam int BTN_L = 1;
    localparam int BTN_R = 2;
    localparam int BTN_D = 3;
    localparam int BTN_U = 4;

    // 10 ms at 25 MHz
    localparam int DEBOUNCE_DEFAULT = 250000;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARM_P   = 2'b01,
        PRESSED = 2'b10,
        ARM_R   = 2'b11
    } btn_state_t;

endpackage

`default_nettype wire

// File: rtl/btn_debounce_ch.sv
// ============================================================================
// Module      : btn_debounce_ch
// Description : One button channel: 2-FF synchroniser, debounce FSM, repeat.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module btn_debounce_ch
    import maze_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int REPEAT_CYCLES   = 0,
    parameter int CNT_W           = 18
) (
    input  logic clk,
    input  logic Reset_n,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam logic [CNT_W-1:0] DC_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RC_LAST   = CNT_W'(REPEAT_CYCLES - 1);
    localparam bit               REPEAT_EN = (REPEAT_CYCLES != 0);

    logic             s1;
    logic             s2;
    btn_state_t       state;
    btn_state_t       state_nx;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] dcnt_nx;
    logic [CNT_W-1:0] rcnt;
    logic [CNT_W-1:0] rcnt_nx;
    logic             pulse_nx;

    always_comb begin
        state_nx = state;
        dcnt_nx  = dcnt;
        rcnt_nx  = rcnt;
        pulse_nx = 1'b0;
        case (state)
            IDLE: begin
                if (s2) begin
                    state_nx = ARM_P;
                    dcnt_nx  = '0;
                end
            end
            ARM_P: begin
                if (!s2) begin
                    state_nx = IDLE;
                end else if (dcnt == DC_LAST) begin
                    state_nx = PRESSED;
                    pulse_nx = 1'b1;
                    rcnt_nx  = '0;
                end else begin
                    dcnt_nx = dcnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s2) begin
                    state_nx = ARM_R;
                    dcnt_nx  = '0;
                end else if (REPEAT_EN) begin
                    // rcnt only runs when repeat is enabled, so it never wraps
                    if (rcnt == RC_LAST) begin
                        pulse_nx = 1'b1;
                        rcnt_nx  = '0;
                    end else begin
                        rcnt_nx = rcnt + CNT_W'(1);
                    end
                end
            end
            ARM_R: begin
                if (s2) begin
                    state_nx = PRESSED;
                    rcnt_nx  = '0;
                end else if (dcnt == DC_LAST) begin
                    state_nx = IDLE;
                end else begin
                    dcnt_nx = dcnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= IDLE;
            dcnt  <= '0;
            rcnt  <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            state <= state_nx;
            dcnt  <= dcnt_nx;
            rcnt  <= rcnt_nx;
            // Level is decoded from the next state so it lines up with the pulse
            level <= (state_nx == PRESSED) || (state_nx == ARM_R);
            pulse <= pulse_nx;
        end
    end

endmodule

`default_nettype wire

// File: rtl/btn_conditioner.sv
// ============================================================================
// Module      : btn_conditioner
// Description : Debounce/edge-detect wrapper for the board push-buttons.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module btn_conditioner
    import maze_pkg::*;
#(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int REPEAT_CYCLES   = 0,
    parameter int CNT_W           = 18
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk     (clk),
            .Reset_n (Reset_n),
            .raw     (btn_raw[i]),
            .level   (btn_level[i]),
            .pulse   (btn_pulse[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_btn_conditioner.sv
// ============================================================================
// Module      : tb_btn_conditioner
// Description : Self-checking bench; DEBOUNCE=4, one instance with repeat=6.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_btn_conditioner;
    import maze_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] raw_a = '0;
    logic [4:0] raw_r = '0;
    logic [4:0] level_a, pulse_a, level_r, pulse_r;

    always #5 clk = ~clk;

    btn_conditioner #(.N_BTN(5), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0), .CNT_W(3)) dut_a (
        .clk(clk), .Reset_n(rst_n), .btn_raw(raw_a), .btn_level(level_a), .btn_pulse(pulse_a)
    );

    btn_conditioner #(.N_BTN(5), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(6), .CNT_W(3)) dut_r (
        .clk(clk), .Reset_n(rst_n), .btn_raw(raw_r), .btn_level(level_r), .btn_pulse(pulse_r)
    );

    typedef struct {
        string      name;
        logic [4:0] lvl_a;
        logic [4:0] pls_a;
        logic [4:0] lvl_r;
        logic [4:0] pls_r;
    } exp_t;

    typedef struct {
        string      name;
        int         n;
        logic       rn;
        logic [4:0] raw;
        logic [4:0] lvl;
        logic [4:0] pls;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    task automatic chk(input string name, input string sig, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d %s actual=%b expected=%b", name, cyc, sig, act, exp);
        end
    endtask

    // Scoreboard consumer: one expected record per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.name, "level_a", level_a, e.lvl_a);
                chk(e.name, "pulse_a", pulse_a, e.pls_a);
                chk(e.name, "level_r", level_r, e.lvl_r);
                chk(e.name, "pulse_r", pulse_r, e.pls_r);
            end
        end
    end

    task automatic step(input string name, input logic rn, input logic [4:0] ra,
                        input logic [4:0] la, input logic [4:0] pa,
                        input logic [4:0] rr, input logic [4:0] lr, input logic [4:0] pr);
        exp_t e;
        @(negedge clk);
        rst_n = rn;
        raw_a = ra;
        raw_r = rr;
        e.name  = name;
        e.lvl_a = la;
        e.pls_a = pa;
        e.lvl_r = lr;
        e.pls_r = pr;
        sb.push_back(e);
    endtask

    function automatic void add(input string name, input int n, input logic rn,
                                input logic [4:0] raw, input logic [4:0] lvl, input logic [4:0] pls);
        vec_t v;
        v.name = name; v.n = n; v.rn = rn; v.raw = raw; v.lvl = lvl; v.pls = pls;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [4:0] b0, b1, b2, b3, b4;
        b0 = 5'b00001 << BTN_C;
        b1 = 5'b00001 << BTN_L;
        b2 = 5'b00001 << BTN_R;
        b3 = 5'b00001 << BTN_D;
        b4 = 5'b00001 << BTN_U;
        b0 = 5'(1) << BTN_C;

        // Reset held with all buttons pressed, then the press is treated as new
        add("rst_hold",    3, 1'b0, 5'h1F, 5'h00, 5'h00);
        add("rst_lat",     6, 1'b1, 5'h1F, 5'h00, 5'h00);
        add("rst_pulse",   1, 1'b1, 5'h1F, 5'h1F, 5'h1F);
        add("rst_held",    3, 1'b1, 5'h1F, 5'h1F, 5'h00);
        add("rst_rel",     6, 1'b1, 5'h00, 5'h1F, 5'h00);
        add("rst_rel_end", 1, 1'b1, 5'h00, 5'h00, 5'h00);
        // Clean press on R
        add("clean_lat",   6, 1'b1, b2,    5'h00, 5'h00);
        add("clean_pulse", 1, 1'b1, b2,    b2,    b2);
        add("clean_held",  3, 1'b1, b2,    b2,    5'h00);
        add("clean_rel",   6, 1'b1, 5'h00, b2,    5'h00);
        add("clean_off",   1, 1'b1, 5'h00, 5'h00, 5'h00);
        // Press bounce on L
        add("bnc_hi",      3, 1'b1, b1,    5'h00, 5'h00);
        add("bnc_lo",      2, 1'b1, 5'h00, 5'h00, 5'h00);
        add("bnc_lat",     6, 1'b1, b1,    5'h00, 5'h00);
        add("bnc_pulse",   1, 1'b1, b1,    b1,    b1);
        add("bnc_held",    2, 1'b1, b1,    b1,    5'h00);
        add("bnc_rel",     6, 1'b1, 5'h00, b1,    5'h00);
        add("bnc_off",     1, 1'b1, 5'h00, 5'h00, 5'h00);
        // Release bounce on C
        add("rb_lat",      6, 1'b1, b0,    5'h00, 5'h00);
        add("rb_pulse",    1, 1'b1, b0,    b0,    b0);
        add("rb_held",     2, 1'b1, b0,    b0,    5'h00);
        add("rb_glitch",   2, 1'b1, 5'h00, b0,    5'h00);
        add("rb_restore",  8, 1'b1, b0,    b0,    5'h00);
        add("rb_rel",      6, 1'b1, 5'h00, b0,    5'h00);
        add("rb_off",      1, 1'b1, 5'h00, 5'h00, 5'h00);

        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++)
                step(tbl[i].name, tbl[i].rn, tbl[i].raw, tbl[i].lvl, tbl[i].pls, 5'h00, 5'h00, 5'h00);
        end

        // Reset lands while D is arming (edge 5): no pulse, and a later press sees full latency
        for (int t = 1; t <= 4; t++) step("mid_arm", 1'b1, b3, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
        step("mid_rst", 1'b0, b3, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
        for (int t = 1; t <= 8; t++) step("mid_after", 1'b1, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
        for (int t = 1; t <= 6; t++) step("mid_relat", 1'b1, b3, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
        step("mid_pulse", 1'b1, b3, b3, b3, 5'h00, 5'h00, 5'h00);
        step("mid_held", 1'b1, b3, b3, 5'h00, 5'h00, 5'h00, 5'h00);
        for (int t = 1; t <= 6; t++) step("mid_rel", 1'b1, 5'h00, b3, 5'h00, 5'h00, 5'h00, 5'h00);
        step("mid_off", 1'b1, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);

        // Repeat on U: pulses every 6 cycles; a 2-cycle glitch at t=31..32 restarts the period at t=35
        for (int t = 1; t <= 48; t++) begin
            logic [4:0] rr, lr, pr;
            rr = (t == 31 || t == 32) ? 5'h00 : b4;
            lr = (t >= 7) ? b4 : 5'h00;
            pr = (t == 7 || t == 13 || t == 19 || t == 25 || t == 31 || t == 41 || t == 47) ? b4 : 5'h00;
            step("repeat", 1'b1, 5'h00, 5'h00, 5'h00, rr, lr, pr);
        end
        for (int t = 1; t <= 6; t++) step("rep_rel", 1'b1, 5'h00, 5'h00, 5'h00, 5'h00, b4, 5'h00);
        step("rep_off", 1'b1, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);

        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain actual=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
